// File: rtl/probe_buffer_feeder.sv
`default_nettype none
// ============================================================================
// Module   : probe_buffer_feeder
// Purpose  : Feeder end of the probe-buffer channel. The host preloads
//            DATA_WIDTH-bit probe words into a circular buffer, and the
//            consumer pulls them one per asserted ren through a registered
//            read port. The block also provides a sticky underflow flag, an
//            occupancy count and a synchronous flush.
// Ports    : clock      - single clock, all state changes on posedge
//            reset      - asynchronous, active-high reset
//            load_valid - host offers load_data
//            load_ready - buffer can take a word ((count != DEPTH) && !clear)
//            load_data  - word offered by the host
//            ren        - read request, one word per asserted cycle
//            read       - registered read data, held until next ren/clear
//            read_valid - one-cycle pulse after a ren that found a real entry
//            underflow  - sticky, set when ren finds the buffer empty
//            clear      - synchronous flush, highest priority
//            count      - current occupancy, 0..DEPTH
// Options  : PROBEBUFF_REPLAY_EN - reads do not consume entries. A replay
//            pointer cycles from the oldest to the newest loaded word and
//            then wraps, so the loaded sequence repeats indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module probe_buffer_feeder #(
  parameter int                    DEPTH       = 16,
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] EMPTY_VALUE = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     ren,
  output logic [DATA_WIDTH-1:0]    read,
  output logic                     read_valid,
  output logic                     underflow,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             CW   = AW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;   // replay pointer in replay mode
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] read_q, read_d;
  logic                  read_valid_q, read_valid_d;
  logic                  underflow_q, underflow_d;

  logic                  load_fire;
  logic                  read_hit;

  // clear forces load_ready low, so a load can never land in a flush cycle.
  assign load_ready = (count_q != FULL) && !clear;
  assign load_fire  = load_valid && load_ready;
  assign read_hit   = ren && (count_q != '0) && !clear;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    read_d       = read_q;
    read_valid_d = 1'b0;
    underflow_d  = underflow_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      read_d      = EMPTY_VALUE;
      underflow_d = 1'b0;
    end else begin
      if (ren) begin
        if (read_hit) begin
          read_d       = mem[rd_ptr_q];
          read_valid_d = 1'b1;
`ifdef PROBEBUFF_REPLAY_EN
          // Wrap back to the oldest word after the newest one present at
          // this edge; a word loaded in the same cycle joins the next lap.
          if (({1'b0, rd_ptr_q} + CW'(1)) == count_q) begin
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
`else
          rd_ptr_d = rd_ptr_q + AW'(1);
`endif
        end else begin
          // No bypass: an empty read underflows even if a load lands now.
          read_d      = EMPTY_VALUE;
          underflow_d = 1'b1;
        end
      end

      if (load_fire) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end

`ifdef PROBEBUFF_REPLAY_EN
      if (load_fire) begin
        count_d = count_q + CW'(1);
      end
`else
      case ({load_fire, read_hit})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      read_q       <= EMPTY_VALUE;
      read_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      read_q       <= read_d;
      read_valid_q <= read_valid_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array carries no reset; pointers and count define its contents.
  always_ff @(posedge clock) begin
    if (load_fire) begin
      mem[wr_ptr_q] <= load_data;
    end
  end

  assign read       = read_q;
  assign read_valid = read_valid_q;
  assign underflow  = underflow_q;
  assign count      = count_q;

endmodule
`default_nettype wire
